// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave cook-time controller:
// state encoding and default timing parameters.
package microwave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_CNT_W       = 10;
  localparam int DEF_MAX_SECS    = 600;
  localparam int DEF_ADD_STEP    = 30;
  localparam int DEF_ALARM_BEATS = 3;

endpackage

// File: rtl/sat_add_sub.sv
// Combinational saturating update: min(a + inc - dec, MAX), floored at 0.
// Zero latency; no flow control.
module sat_add_sub #(
  parameter int CNT_W = 10,
  parameter int MAX   = 600
) (
  input  logic [CNT_W-1:0] i_a,
  input  logic [CNT_W-1:0] i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_y
);

  logic [CNT_W:0] w_sum;
  logic [CNT_W:0] w_diff;
  logic [CNT_W:0] w_max;

  // One extra bit of headroom so a + inc can never wrap before the clamp.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_inc};
  assign w_max  = (CNT_W+1)'(MAX);
  assign w_diff = (w_sum >= {{CNT_W{1'b0}}, i_dec}) ? (w_sum - {{CNT_W{1'b0}}, i_dec})
                                                    : '0;
  assign o_y    = (w_diff > w_max) ? w_max[CNT_W-1:0] : w_diff[CNT_W-1:0];

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Cook-time controller: IDLE/COOK/PAUSE/DONE FSM holding remaining seconds,
// driving the 1 Hz divider enable/reset and the magnetron/alarm outputs.
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MAX_SECS    = DEF_MAX_SECS,
  parameter int ADD_STEP    = DEF_ADD_STEP,
  parameter int ALARM_BEATS = DEF_ALARM_BEATS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             add_time,
  input  logic             door_open,
  input  logic             beat,
  output logic             div_enable,
  output logic             div_reset,
  output logic             magnetron_on,
  output logic             alarm,
  output logic [CNT_W-1:0] remaining,
  output logic [1:0]       state
);

  localparam int AW = (ALARM_BEATS > 1) ? $clog2(ALARM_BEATS + 1) : 1;

  state_t           r_state, w_nxt_state;
  logic [CNT_W-1:0] r_remaining, w_nxt_remaining;
  logic [AW-1:0]    r_alarm_cnt, w_nxt_alarm_cnt;
  logic             r_div_reset, w_nxt_div_reset;

  logic [CNT_W-1:0] w_inc;
  logic             w_dec;
  logic [CNT_W-1:0] w_sat;

  sat_add_sub #(
    .CNT_W (CNT_W),
    .MAX   (MAX_SECS)
  ) u_sat (
    .i_a   (r_remaining),
    .i_inc (w_inc),
    .i_dec (w_dec),
    .o_y   (w_sat)
  );

  // Beats only count down while cooking and not being paused this cycle.
  assign w_inc = (add_time && r_state != DONE) ? CNT_W'(ADD_STEP) : '0;
  assign w_dec = (r_state == COOK) && beat && !stop && !door_open;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_alarm_cnt <= '0;
      r_div_reset <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_remaining <= w_nxt_remaining;
      r_alarm_cnt <= w_nxt_alarm_cnt;
      r_div_reset <= w_nxt_div_reset;
    end
  end

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_remaining = r_remaining;
    w_nxt_alarm_cnt = r_alarm_cnt;
    w_nxt_div_reset = 1'b0;
    case (r_state)
      IDLE: begin
        if (stop) begin
          w_nxt_remaining = '0;
        end else begin
          w_nxt_remaining = w_sat;
          if (start && r_remaining != '0 && !door_open) begin
            w_nxt_state     = COOK;
            w_nxt_div_reset = 1'b1;
          end
        end
      end
      COOK: begin
        w_nxt_remaining = w_sat;
        if (stop || door_open) begin
          w_nxt_state = PAUSE;
        end else if (w_dec && w_sat == '0) begin
          w_nxt_state     = DONE;
          w_nxt_alarm_cnt = '0;
        end
      end
      PAUSE: begin
        if (stop) begin
          w_nxt_state     = IDLE;
          w_nxt_remaining = '0;
        end else begin
          w_nxt_remaining = w_sat;
          if (!door_open && start) w_nxt_state = COOK;
        end
      end
      DONE: begin
        if (stop || door_open) begin
          w_nxt_state = IDLE;
        end else if (beat) begin
          if (r_alarm_cnt == AW'(ALARM_BEATS - 1)) begin
            w_nxt_state     = IDLE;
            w_nxt_alarm_cnt = '0;
          end else begin
            w_nxt_alarm_cnt = r_alarm_cnt + 1'b1;
          end
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  assign div_enable   = (r_state == COOK) || (r_state == DONE);
  assign magnetron_on = (r_state == COOK);
  assign alarm        = (r_state == DONE);
  assign div_reset    = r_div_reset;
  assign remaining    = r_remaining;
  assign state        = r_state;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed bench for microwave_timer_ctrl: hand-computed expectations
// checked with immediate assertions.
module tb_microwave_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       add_time = 1'b0;
  logic       door_open = 1'b0;
  logic       beat = 1'b0;
  logic       div_enable, div_reset, magnetron_on, alarm;
  logic [9:0] remaining;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  microwave_timer_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .add_time     (add_time),
    .door_open    (door_open),
    .beat         (beat),
    .div_enable   (div_enable),
    .div_reset    (div_reset),
    .magnetron_on (magnetron_on),
    .alarm        (alarm),
    .remaining    (remaining),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Apply one cycle of pulse inputs (door is a level), then sample #1 after the edge.
  task automatic cyc(input logic s, input logic p, input logic a, input logic b);
    start = s; stop = p; add_time = a; beat = b;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; add_time = 1'b0; beat = 1'b0;
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1);
  endtask

  initial begin
    #12;
    chk("rst_state", 32'(state), 0);
    chk("rst_rem", 32'(remaining), 0);
    chk("rst_outs", {div_enable, div_reset, magnetron_on, alarm}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: two adds, start, count down to DONE
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("t1_rem60", 32'(remaining), 60);
    chk("t1_idle", 32'(state), 0);
    cyc(1, 0, 0, 0);
    chk("t1_cook", 32'(state), 1);
    chk("t1_divrst_hi", 32'(div_reset), 1);
    chk("t1_mag", 32'(magnetron_on), 1);
    chk("t1_diven", 32'(div_enable), 1);
    cyc(0, 0, 0, 0);
    chk("t1_divrst_lo", 32'(div_reset), 0);
    beats(59);
    chk("t1_rem1", 32'(remaining), 1);
    chk("t1_still_cook", 32'(state), 1);
    beats(1);
    chk("t1_done", 32'(state), 3);
    chk("t1_rem0", 32'(remaining), 0);
    chk("t1_alarm", 32'(alarm), 1);
    chk("t1_mag_off", 32'(magnetron_on), 0);

    // 2: add ignored in DONE, alarm beats, and stop in DONE
    cyc(0, 0, 1, 0);
    chk("t2_add_ign", 32'(remaining), 0);
    beats(2);
    chk("t2_done_2b", 32'(state), 3);
    chk("t2_alarm_2b", 32'(alarm), 1);
    beats(1);
    chk("t2_idle_3b", 32'(state), 0);
    chk("t2_alarm_off", 32'(alarm), 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    beats(30);
    chk("t2_done_again", 32'(state), 3);
    cyc(0, 1, 0, 0);
    chk("t2_stop_idle", 32'(state), 0);

    // 3: door opens with a beat at 45 -> PAUSE, beat dropped
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    beats(15);
    chk("t3_rem45", 32'(remaining), 45);
    door_open = 1'b1;
    cyc(0, 0, 0, 1);
    chk("t3_pause", 32'(state), 2);
    chk("t3_rem_held", 32'(remaining), 45);
    chk("t3_diven0", 32'(div_enable), 0);
    cyc(1, 0, 0, 0);
    chk("t3_door_blocks", 32'(state), 2);
    door_open = 1'b0;
    cyc(1, 0, 0, 0);
    chk("t3_resume", 32'(state), 1);
    chk("t3_no_divrst", 32'(div_reset), 0);
    cyc(0, 0, 1, 0);
    chk("t3_add_cook", 32'(remaining), 75);

    // 4: saturation at 600, including add+beat at 590
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("t4_cleared", 32'(remaining), 0);
    for (int i = 0; i < 25; i++) cyc(0, 0, 1, 0);
    chk("t4_sat600", 32'(remaining), 600);
    cyc(1, 0, 0, 0);
    beats(10);
    chk("t4_rem590", 32'(remaining), 590);
    cyc(0, 0, 1, 1);
    chk("t4_addbeat600", 32'(remaining), 600);
    cyc(0, 0, 1, 1);
    chk("t4_addbeat_sat", 32'(remaining), 600);

    // 5: start with zero time; start+stop together
    cyc(0, 1, 0, 0);
    chk("t5_pause", 32'(state), 2);
    cyc(0, 1, 0, 0);
    chk("t5_idle", 32'(state), 0);
    cyc(1, 0, 0, 0);
    chk("t5_start_zero", 32'(state), 0);
    cyc(0, 0, 1, 0);
    chk("t5_rem30", 32'(remaining), 30);
    cyc(1, 1, 0, 0);
    chk("t5_ss_idle", 32'(state), 0);
    chk("t5_ss_rem0", 32'(remaining), 0);

    // 6: asynchronous reset mid-COOK
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    beats(3);
    chk("t6_cook", 32'(state), 1);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_async_state", 32'(state), 0);
    chk("t6_async_rem", 32'(remaining), 0);
    chk("t6_async_outs", {div_enable, div_reset, magnetron_on, alarm}, 0);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    beats(5);
    chk("t6_post_idle", 32'(state), 0);
    chk("t6_post_rem", 32'(remaining), 0);
    chk("t6_post_mag", 32'(magnetron_on), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/microwave_timer_ctrl.md
Name: microwave_timer_ctrl

Overview:
Cook-time controller for the microwave FSM lab. It holds the remaining cook time in seconds and runs an IDLE/COOK/PAUSE/DONE state machine. It drives the enable and synchronous reset of the 1 Hz clock divider, and consumes that divider's one-cycle beat pulse as its seconds tick. It sits between the debounced button/door inputs and the magnetron, display and alarm outputs.

Parameters:
CNT_W, 10, width of the remaining-seconds counter.
MAX_SECS, 600, saturation ceiling for remaining time; must be less than 2**CNT_W.
ADD_STEP, 30, seconds added per add_time pulse.
ALARM_BEATS, 3, number of beats the alarm stays on in DONE; must be at least 1.

Ports:
clk  input  1  system clock (100 MHz board clock).
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse: start or resume cooking.
stop  input  1  one-cycle pulse: pause, or cancel.
add_time  input  1  one-cycle pulse: add ADD_STEP seconds.
door_open  input  1  level, synchronised upstream.
beat  input  1  one-cycle pulse per second from the clock divider.
div_enable  output  1  counting enable to the divider.
div_reset  output  1  one-cycle reset pulse to the divider.
magnetron_on  output  1  heater drive.
alarm  output  1  done buzzer/LED.
remaining  output  CNT_W  seconds left, for the display.
state  output  2  IDLE=0, COOK=1, PAUSE=2, DONE=3.

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-high and forces every register.
- Reset values: state=IDLE, remaining=0, alarm beat count=0. All outputs are 0.
- Output registering: all outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- Output decode: div_enable=1 in COOK and DONE. magnetron_on=1 only in COOK. alarm=1 only in DONE.
- Add rule: remaining <= min(remaining + ADD_STEP, MAX_SECS). The sum is computed at CNT_W+1 bits so it cannot wrap. add_time is honoured in IDLE, COOK and PAUSE, and ignored in DONE.
- IDLE:
  - stop clears remaining to 0.
  - start with remaining>0 and door_open=0 goes to COOK; div_reset pulses high for the first COOK cycle.
  - start with remaining=0 or door open is ignored.
- COOK:
  - On beat, remaining decrements by 1.
  - A beat while remaining=1 sets remaining=0 and goes to DONE; the alarm beat count clears to 0.
  - stop or door_open goes to PAUSE. In that cycle any beat is dropped and any add_time is still applied.
  - beat and add_time in the same cycle give remaining <= min(remaining - 1 + ADD_STEP, MAX_SECS).
- PAUSE:
  - div_enable=0, so the divider holds its partial second.
  - start with door_open=0 returns to COOK with no div_reset pulse.
  - stop goes to IDLE and clears remaining to 0.
- DONE:
  - Each beat increments the alarm beat count. On the ALARM_BEATS-th beat, go to IDLE.
  - stop or door_open goes to IDLE immediately.
- Priority within one cycle: reset > stop > door_open > start > beat. start and stop together resolve as stop.
- Reset mid-COOK: all outputs return to 0 asynchronously and no further beats are honoured until start.

Decomposition:
- Shared package microwave_pkg holds:
  - the state encoding constants (IDLE/COOK/PAUSE/DONE);
  - the defaults for ADD_STEP and MAX_SECS.
- Sub-module sat_add_sub: combinational min(a + inc - dec, MAX) at CNT_W+1 bits. It is the one natural split.
- The FSM, the remaining register and the alarm counter stay in microwave_timer_ctrl.
- The top level instantiates this block next to the clock divider, with THRESHOLD set for 1 Hz in hardware and small in simulation.

Test Plan:
1. Two add_time pulses then start (door closed) -> remaining=60, state=COOK, div_reset high for exactly 1 cycle, magnetron_on=1. After 60 beats: state=DONE, remaining=0, alarm=1, magnetron_on=0.
2. From DONE, 3 beats -> state=IDLE and alarm=0 on the cycle after the 3rd beat. Separately, stop in DONE -> IDLE on the next cycle.
3. COOK with remaining=45, door_open asserted in the same cycle as a beat -> state=PAUSE, remaining=45, div_enable=0. Then start while door open -> stays PAUSE. Close door and start -> COOK, no div_reset pulse.
4. 25 add_time pulses in IDLE -> remaining saturates at 600. In COOK at remaining=590, add_time and beat in the same cycle -> remaining=600.
5. IDLE with remaining=0, start -> stays IDLE. Then start and stop in the same cycle with remaining=30 -> stays IDLE, remaining=0.
6. Assert reset asynchronously mid-COOK, between clock edges -> all outputs 0 immediately. After release, beats are ignored and state stays IDLE.
